mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit words of internal data memory (power of two).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 ex_valid  in  1  EX/MEM slot holds a valid instruction.
REQ-005 ex_alu_result  in  32  byte address for loads/stores; result value for other ops.
REQ-006 ex_store_data  in  32  store source register value.
REQ-007 ex_mem_read / ex_mem_write  in  1 each  load / store; never both 1.
REQ-008 ex_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 ex_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-010 ex_reg_write  in  1 and ex_rd  in  5  destination write enable and register index.
REQ-011 stall_in  in  1 and flush_in  in  1  hold stage / kill current slot.
REQ-012 wb_valid, wb_reg_write  out  1 each; wb_rd  out  5; wb_data  out  32  MEM/WB payload.
REQ-013 misalign  out  1 and badaddr  out  32  misaligned-access flag and faulting address.

Function
REQ-014 Latency is one cycle: the slot accepted at edge N appears on wb_* after edge N.
REQ-015 Accept condition is ~stall_in & ~flush_in; a load reads RAM only when ex_valid & ex_mem_read and the slot is accepted.
REQ-016 stall_in=1 (flush_in=0): all wb_* outputs, misalign, badaddr and the RAM read register hold; no RAM write.
REQ-017 flush_in=1 overrides stall_in: wb_valid, wb_reg_write and misalign cleared; no RAM write; wb_data and wb_rd don't-care.
REQ-018 Non-memory op: wb_data = ex_alu_result; wb_reg_write = ex_valid & ex_reg_write.
REQ-019 Word index = ex_alu_result[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap).
REQ-020 Byte lanes are little-endian: byte at addr[1:0]=k occupies bits 8k+7:8k.
REQ-021 Store byte writes lane addr[1:0] with store_data[7:0]; half writes lanes addr[1]*2..+1 with store_data[15:0]; word writes all lanes.
REQ-022 The load result is extracted from the RAM output using the registered size, lane and unsigned flag, then zero- or sign-extended to 32 bits.
REQ-023 A load in the cycle after a store to the same word returns the newly written data.
REQ-024 Stores produce wb_reg_write=0 and wb_valid = ex_valid.
REQ-025 Misaligned means half with addr[0]=1, or word/11 with addr[1:0]!=0.

Reset
REQ-026 reset=1 immediately forces wb_valid, wb_reg_write, wb_rd, wb_data, misalign and badaddr to 0, including mid-operation.
REQ-027 RAM contents are not reset; an accepted store is lost if reset asserts before its edge.

Configuration
REQ-028 Macro MEM_STAGE_MISALIGN_TRAP_EN defined: a misaligned accepted access suppresses its store and its wb_reg_write, and sets misalign=1 for one cycle with wb_valid=1. badaddr captures the address and holds it until the next misalign.
REQ-029 Macro undefined: low address bits are forced to natural alignment (half clears bit 0, word clears bits 1:0); misalign and badaddr are tied to 0.

Structure
REQ-030 Shared package mem_pkg holds the size encodings SZ_BYTE, SZ_HALF, SZ_WORD and the lane-extract/extend function.
REQ-031 One sub-module, data_ram, provides the synchronous single-port RAM with 4 byte-write enables and a registered read port with enable.

Verification
REQ-032 Reset pulse mid-stream -> all outputs 0 in the same cycle; the next accepted ALU op (rd=5, result 0x1234) gives wb_data=0x1234 and wb_reg_write=1.
REQ-033 sw 0xDEADBEEF @0x10 -> then:
  - lbu @0x11 gives 0x000000BE;
  - lb @0x13 gives 0xFFFFFFDE;
  - lh @0x12 gives 0xFFFFDEAD.
REQ-034 sb 0x55 @0x12, then lw @0x10 on the next cycle -> 0xDE55BEEF.
REQ-035 lw @0x12 with the macro defined -> misalign=1, wb_reg_write=0, badaddr=0x12. With the macro undefined -> returns the word at 0x10.
REQ-036 Store held under stall_in for 3 cycles -> exactly one write and wb_* frozen. Store with flush_in=1 -> memory unchanged and wb_valid=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: access-size encodings, the write-back
// slot record and the byte-lane helpers used for both stores and loads.
package mem_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        is_load;
    size_e       size;
    logic [1:0]  lane;
    logic        unsgn;
  } wb_slot_t;

  function automatic logic [NUM_LANES-1:0] be_mask(input size_e size, input logic [1:0] lane);
    logic [NUM_LANES-1:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
    return ((size == SZ_HALF) && lane[0]) ||
           (((size == SZ_WORD) || (size == SZ_RSVD)) && (lane != 2'b00));
  endfunction

  // Pull the addressed byte/half out of the little-endian word and extend it.
  function automatic logic [31:0] ld_extract(input logic [31:0] word, input size_e size,
                                             input logic [1:0] lane, input logic unsgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = {{24{~unsgn & b[7]}}, b};
      SZ_HALF: res = {{16{~unsgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM slot and MEM/WB payload bundle; master is the pipeline side, slave the mem stage.
interface mem_stage_if;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;

  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
           ex_size, ex_unsigned, ex_reg_write, ex_rd,
    input  wb_valid, wb_reg_write, wb_rd, wb_data
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
           ex_size, ex_unsigned, ex_reg_write, ex_rd,
    output wb_valid, wb_reg_write, wb_rd, wb_data
  );
endinterface

// File: rtl/mem_stage_data_ram.sv
// Single-port data RAM split into byte lanes: per-lane write enable, registered read with enable.
module data_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      i_en,
  input  logic [NUM_LANES-1:0]      i_we,
  input  logic [AW-1:0]             i_addr,
  input  logic [NUM_LANES-1:0][7:0] i_wdata,
  output logic [NUM_LANES-1:0][7:0] o_rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_we[l]) r_mem[i_addr] <= i_wdata[l];
      if (i_en)    r_q           <= r_mem[i_addr];
    end

    assign o_rdata[l] = r_q;
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: one-cycle loads/stores into internal RAM, pass-through for ALU ops.
// Optional MEM_STAGE_MISALIGN_TRAP_EN traps misaligned accesses instead of force-aligning them.
module mem_stage
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        flush_in,
  mem_stage_if.slave  mem_if,
  output logic        misalign,
  output logic [31:0] badaddr
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic                      w_accept;
  logic                      w_mem;
  logic                      w_trap;
  logic                      w_re;
  size_e                     w_size;
  logic [AW+1:0]             w_addr;
  logic [NUM_LANES-1:0]      w_we;
  logic [NUM_LANES-1:0][7:0] w_wdata;
  logic [NUM_LANES-1:0][7:0] w_rdata;
  wb_slot_t                  r_slot;

  assign w_accept = ~stall_in & ~flush_in;
  assign w_size   = size_e'(mem_if.ex_size);
  assign w_mem    = mem_if.ex_valid & (mem_if.ex_mem_read | mem_if.ex_mem_write);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign w_addr = mem_if.ex_alu_result[AW+1:0];
  assign w_trap = w_mem & is_misaligned(w_size, mem_if.ex_alu_result[1:0]);
`else
  always_comb begin
    w_addr = mem_if.ex_alu_result[AW+1:0];
    case (w_size)
      SZ_HALF:          w_addr[0]   = 1'b0;
      SZ_WORD, SZ_RSVD: w_addr[1:0] = 2'b00;
      default: ;
    endcase
  end
  assign w_trap = 1'b0;
`endif

  // A store or load landing on an edge while reset is high is dropped.
  assign w_we = (w_accept & ~reset & mem_if.ex_valid & mem_if.ex_mem_write & ~w_trap)
              ? be_mask(w_size, w_addr[1:0]) : '0;
  assign w_re = w_accept & ~reset & mem_if.ex_valid & mem_if.ex_mem_read;

  always_comb begin
    w_wdata = mem_if.ex_store_data;
    case (w_size)
      SZ_BYTE: w_wdata = {4{mem_if.ex_store_data[7:0]}};
      SZ_HALF: w_wdata = {2{mem_if.ex_store_data[15:0]}};
      default: ;
    endcase
  end

  data_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .i_en    (w_re),
    .i_we    (w_we),
    .i_addr  (w_addr[AW+1:2]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot <= '0;
    end else if (flush_in) begin
      r_slot.valid     <= 1'b0;
      r_slot.reg_write <= 1'b0;
    end else if (!stall_in) begin
      r_slot.valid     <= mem_if.ex_valid;
      r_slot.reg_write <= mem_if.ex_valid & mem_if.ex_reg_write & ~mem_if.ex_mem_write & ~w_trap;
      r_slot.rd        <= mem_if.ex_rd;
      r_slot.data      <= mem_if.ex_alu_result;
      r_slot.is_load   <= mem_if.ex_valid & mem_if.ex_mem_read;
      r_slot.size      <= w_size;
      r_slot.lane      <= w_addr[1:0];
      r_slot.unsgn     <= mem_if.ex_unsigned;
    end
  end

  assign mem_if.wb_valid     = r_slot.valid;
  assign mem_if.wb_reg_write = r_slot.reg_write;
  assign mem_if.wb_rd        = r_slot.rd;
  assign mem_if.wb_data      = r_slot.is_load
                             ? ld_extract(w_rdata, r_slot.size, r_slot.lane, r_slot.unsgn)
                             : r_slot.data;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic        r_mis;
  logic [31:0] r_badaddr;

  // badaddr is sticky until the next trap; misalign lasts one accepted cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mis     <= 1'b0;
      r_badaddr <= '0;
    end else if (flush_in) begin
      r_mis <= 1'b0;
    end else if (!stall_in) begin
      r_mis <= w_trap;
      if (w_trap) r_badaddr <= mem_if.ex_alu_result;
    end
  end

  assign misalign = r_mis;
  assign badaddr  = r_badaddr;
`else
  assign misalign = 1'b0;
  assign badaddr  = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU pass-through, lane extract/extend, stall/flush, alignment.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        misalign;
  logic [31:0] badaddr;
  int          n_chk = 0;
  int          n_err = 0;

  mem_stage_if mif();

  mem_stage #(.DEPTH_WORDS(1024)) dut (
    .clk      (clk),
    .reset    (reset),
    .stall_in (stall_in),
    .flush_in (flush_in),
    .mem_if   (mif),
    .misalign (misalign),
    .badaddr  (badaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic [1:0] sz,
                       input logic uns, input logic regw, input logic [4:0] rd,
                       input logic [31:0] addr, input logic [31:0] sd);
    mif.ex_valid      = v;
    mif.ex_mem_read   = rd_en;
    mif.ex_mem_write  = wr_en;
    mif.ex_size       = sz;
    mif.ex_unsigned   = uns;
    mif.ex_reg_write  = regw;
    mif.ex_rd         = rd;
    mif.ex_alu_result = addr;
    mif.ex_store_data = sd;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val);
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, rd, val, 32'h0);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, 1'b0, 1'b1, sz, 1'b0, 1'b0, 5'd0, addr, data);
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [4:0] rd, input logic [31:0] addr);
    drive(1'b1, 1'b1, 1'b0, sz, uns, 1'b1, rd, addr, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, mif.wb_valid, 0);
    chk({tag, "_regw"},  mif.wb_reg_write, 0);
    chk({tag, "_rd"},    mif.wb_rd, 0);
    chk({tag, "_data"},  mif.wb_data, 0);
    chk({tag, "_mis"},   misalign, 0);
    chk({tag, "_bad"},   badaddr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #1 reset = 1'b1;
    #1 chk_zero("rst");
    repeat (2) tick();
    reset = 1'b0;

    alu(5'd3, 32'h0000A5A5); tick();
    chk("alu_data", mif.wb_data, 32'h0000A5A5);
    chk("alu_regw", mif.wb_reg_write, 1);
    chk("alu_rd",   mif.wb_rd, 3);

    st(2'b10, 32'h10, 32'hDEADBEEF); tick();
    chk("sw_valid", mif.wb_valid, 1);
    chk("sw_regw",  mif.wb_reg_write, 0);

    ld(2'b00, 1'b1, 5'd1, 32'h11); tick();
    chk("lbu_11", mif.wb_data, 32'h000000BE);
    chk("lbu_regw", mif.wb_reg_write, 1);
    ld(2'b00, 1'b0, 5'd1, 32'h13); tick();
    chk("lb_13", mif.wb_data, 32'hFFFFFFDE);
    ld(2'b01, 1'b0, 5'd1, 32'h12); tick();
    chk("lh_12", mif.wb_data, 32'hFFFFDEAD);

    st(2'b00, 32'h12, 32'h00000055); tick();
    ld(2'b10, 1'b0, 5'd2, 32'h10); tick();
    chk("sb_lw", mif.wb_data, 32'hDE55BEEF);

    ld(2'b10, 1'b0, 5'd4, 32'h12); tick();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    chk("mis_flag",  misalign, 1);
    chk("mis_regw",  mif.wb_reg_write, 0);
    chk("mis_valid", mif.wb_valid, 1);
    chk("mis_bad",   badaddr, 32'h12);
    alu(5'd6, 32'h66); tick();
    chk("mis_clr", misalign, 0);
    chk("bad_hold", badaddr, 32'h12);
    st(2'b10, 32'h11, 32'hFFFFFFFF); tick();
    chk("mis_st_flag", misalign, 1);
    ld(2'b10, 1'b0, 5'd6, 32'h10); tick();
    chk("mis_st_drop", mif.wb_data, 32'hDE55BEEF);
`else
    chk("algn_lw",  mif.wb_data, 32'hDE55BEEF);
    chk("algn_mis", misalign, 0);
    chk("algn_bad", badaddr, 0);
    ld(2'b01, 1'b1, 5'd6, 32'h13); tick();
    chk("algn_lhu", mif.wb_data, 32'h0000DE55);
`endif

    ld(2'b10, 1'b0, 5'd2, 32'h1010); tick();
    chk("wrap", mif.wb_data, 32'hDE55BEEF);

    // Stalled store that is later flushed must never reach memory.
    st(2'b10, 32'h20, 32'hCAFEF00D); tick();
    ld(2'b10, 1'b0, 5'd7, 32'h20); tick();
    chk("ld_20", mif.wb_data, 32'hCAFEF00D);
    st(2'b10, 32'h20, 32'h11223344);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data",  mif.wb_data, 32'hCAFEF00D);
      chk("stall_rd",    mif.wb_rd, 7);
      chk("stall_valid", mif.wb_valid, 1);
    end
    flush_in = 1'b1; tick();
    chk("flush_valid", mif.wb_valid, 0);
    chk("flush_regw",  mif.wb_reg_write, 0);
    stall_in = 1'b0; flush_in = 1'b0;
    ld(2'b10, 1'b0, 5'd8, 32'h20); tick();
    chk("flush_nowr", mif.wb_data, 32'hCAFEF00D);

    st(2'b10, 32'h24, 32'h11223344);
    stall_in = 1'b1;
    repeat (3) tick();
    chk("stall2_data", mif.wb_data, 32'hCAFEF00D);
    chk("stall2_rd",   mif.wb_rd, 8);
    stall_in = 1'b0; tick();
    chk("rel_valid", mif.wb_valid, 1);
    chk("rel_regw",  mif.wb_reg_write, 0);
    ld(2'b10, 1'b0, 5'd9, 32'h24); tick();
    chk("rel_wr", mif.wb_data, 32'h11223344);

    // Async reset mid-cycle; the store on the inputs across that edge is lost.
    alu(5'd2, 32'hBEEF); tick();
    chk("pre_rst", mif.wb_data, 32'hBEEF);
    st(2'b10, 32'h10, 32'h99999999);
    #3 reset = 1'b1;
    #1 chk_zero("mid_rst");
    @(posedge clk);
    #1 reset = 1'b0;
    alu(5'd5, 32'h1234); tick();
    chk("post_data", mif.wb_data, 32'h1234);
    chk("post_regw", mif.wb_reg_write, 1);
    chk("post_rd",   mif.wb_rd, 5);
    ld(2'b10, 1'b0, 5'd1, 32'h10); tick();
    chk("rst_st_lost", mif.wb_data, 32'hDE55BEEF);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
